// File: rtl/vdp_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vdp_cmd_ctrl : VDP CPU command port decoder (control/data ports, VRAM/CRAM/reg)
// Revision     : 1.0
// ============================================================================
module vdp_cmd_ctrl (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        wr_stb,
  input  logic        rd_stb,
  input  logic        port_sel,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic [13:0] vram_addr,
  output logic        vram_re,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        vram_ack,
  output logic        cram_we,
  output logic [4:0]  cram_addr,
  output logic [7:0]  cram_wdata,
  output logic        reg_we,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  status_in,
  output logic        status_clr,
  output logic        busy,
  output logic        ovr_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VRD  = 2'd1,
    ST_VWR  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        flag_q, flag_d;
  logic [1:0]  code_q, code_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  dout_q, dout_d;
  logic [13:0] vaddr_q, vaddr_d;
  logic [7:0]  vwdata_q, vwdata_d;
  logic        cram_we_q, cram_we_d;
  logic [4:0]  cram_addr_q, cram_addr_d;
  logic [7:0]  cram_wdata_q, cram_wdata_d;
  logic        reg_we_q, reg_we_d;
  logic [3:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        status_clr_q, status_clr_d;
  logic        ovr_q, ovr_d;
  logic        busy_w;
  logic [4:0]  status_unused;

  // Only the top three render status flags are visible to the CPU.
  assign status_unused = status_in[4:0];
  assign busy_w        = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    flag_d       = flag_q;
    code_d       = code_q;
    addr_d       = addr_q;
    rbuf_d       = rbuf_q;
    dout_d       = dout_q;
    vaddr_d      = vaddr_q;
    vwdata_d     = vwdata_q;
    cram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_wdata_d = cram_wdata_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    status_clr_d = 1'b0;
    ovr_d        = 1'b0;

    if (busy_w) begin
      // Strobes during an outstanding request, including its ack cycle, are dropped.
      ovr_d = wr_stb | rd_stb;
      if (vram_ack) begin
        addr_d  = addr_q + 14'd1;
        state_d = ST_IDLE;
        if (state_q == ST_VRD) begin
          rbuf_d = vram_rdata;
        end
      end
    end else if (wr_stb) begin
      ovr_d = rd_stb;
      if (port_sel) begin
        if (!flag_q) begin
          addr_d[7:0] = cpu_din;
          flag_d      = 1'b1;
        end else begin
          flag_d       = 1'b0;
          code_d       = cpu_din[7:6];
          addr_d[13:8] = cpu_din[5:0];
          case (cpu_din[7:6])
            2'b00: begin
              state_d = ST_VRD;
              vaddr_d = {cpu_din[5:0], addr_q[7:0]};
            end
            2'b10: begin
              if (cpu_din[3:0] <= 4'd10) begin
                reg_we_d    = 1'b1;
                reg_addr_d  = cpu_din[3:0];
                reg_wdata_d = addr_q[7:0];
              end
            end
            default: ;
          endcase
        end
      end else begin
        flag_d = 1'b0;
        rbuf_d = cpu_din;
        if (code_q == 2'b11) begin
          cram_we_d    = 1'b1;
          cram_addr_d  = addr_q[4:0];
          cram_wdata_d = cpu_din;
          addr_d       = addr_q + 14'd1;
        end else begin
          state_d  = ST_VWR;
          vaddr_d  = addr_q;
          vwdata_d = cpu_din;
        end
      end
    end else if (rd_stb) begin
      flag_d = 1'b0;
      if (port_sel) begin
        dout_d       = {status_in[7:5], 5'b0};
        status_clr_d = 1'b1;
      end else begin
        dout_d  = rbuf_q;
        state_d = ST_VRD;
        vaddr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      flag_q       <= 1'b0;
      code_q       <= 2'b00;
      addr_q       <= 14'd0;
      rbuf_q       <= 8'd0;
      dout_q       <= 8'd0;
      vaddr_q      <= 14'd0;
      vwdata_q     <= 8'd0;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= 5'd0;
      cram_wdata_q <= 8'd0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 4'd0;
      reg_wdata_q  <= 8'd0;
      status_clr_q <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      code_q       <= code_d;
      addr_q       <= addr_d;
      rbuf_q       <= rbuf_d;
      dout_q       <= dout_d;
      vaddr_q      <= vaddr_d;
      vwdata_q     <= vwdata_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_wdata_q <= cram_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      status_clr_q <= status_clr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign cpu_dout   = dout_q;
  assign vram_addr  = vaddr_q;
  assign vram_re    = (state_q == ST_VRD);
  assign vram_we    = (state_q == ST_VWR);
  assign vram_wdata = vwdata_q;
  assign cram_we    = cram_we_q;
  assign cram_addr  = cram_addr_q;
  assign cram_wdata = cram_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;
  assign status_clr = status_clr_q;
  assign busy       = busy_w;
  assign ovr_err    = ovr_q;

endmodule
`default_nettype wire
